if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, IF/ID pipeline register.
- Directly downstream of the stall controller; consumes its PC_NOPE, IF_ID_Reg_Rst and Jump_kind outputs.
- Also takes the redirect pulse and targets from the decode/branch logic.
- Drives the instruction-memory address and feeds the decode stage.

---
 rtl/if_fetch_stage.sv | 94 +++++++++
 tb/tb_if_fetch_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PC_NOPE,
  input  logic        IF_ID_Reg_Rst,
  input  logic        Jump_kind,
  input  logic        redirect_valid,
  input  logic [31:0] imm_target,
  input  logic [31:0] reg_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        halted
);

  logic        pending;
  logic [31:0] pending_tgt;
  logic [31:0] tgt;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        take_redirect;
  logic        take_pending;
  logic        target_applied;

  // Target selection (word aligned) and which control-flow source wins this edge
  always_comb begin
    tgt            = (Jump_kind ? reg_target : imm_target) & 32'hFFFF_FFFC;
    pc_plus4       = pc + 32'd4;
    advance        = !halted && !PC_NOPE;
    take_redirect  = advance && redirect_valid;
    take_pending   = advance && !redirect_valid && pending;
    target_applied = take_redirect || take_pending;
  end

  assign imem_addr = pc;

  // Remember a redirect that arrived while stalled; a newer one overwrites it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending     <= 1'b0;
      pending_tgt <= 32'h0;
    end else if (!halted && redirect_valid && PC_NOPE) begin
      pending     <= 1'b1;
      pending_tgt <= tgt;
    end else if (target_applied) begin
      pending     <= 1'b0;
    end
  end

  // PC register: halt and stall hold, then live redirect, then pending, then sequential
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc <= PC_RESET;
    end else if (take_redirect) begin
      pc <= tgt;
    end else if (take_pending) begin
      pc <= pending_tgt;
    end else if (advance) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register: flush beats stall; a fetched halt word is delivered and sets halted
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      if_id_instr    <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
      fetch_count    <= 32'h0;
      halted         <= 1'b0;
    end else if (IF_ID_Reg_Rst || halted || target_applied) begin
      if_id_instr    <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
    end else if (!PC_NOPE) begin
      if_id_instr    <= imem_rdata;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
      fetch_count    <= fetch_count + 32'd1;
      if (imem_rdata == HALT_WORD) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        PC_NOPE, IF_ID_Reg_Rst, Jump_kind, redirect_valid;
  logic [31:0] imm_target, reg_target;
  logic [31:0] imem_addr, imem_rdata, pc, if_id_instr, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, halted;

  logic        halt_en = 1'b0;
  logic [31:0] halt_addr = 32'h0;

  int vectors = 0;
  int miscompares = 0;

  if_fetch_stage dut (
    .CLK(CLK), .RST_N(RST_N), .PC_NOPE(PC_NOPE), .IF_ID_Reg_Rst(IF_ID_Reg_Rst),
    .Jump_kind(Jump_kind), .redirect_valid(redirect_valid),
    .imm_target(imm_target), .reg_target(reg_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // Instruction memory: word n holds 0x20080001 + n*0x00010001, with an optional halt word
  assign imem_rdata = (halt_en && imem_addr == halt_addr) ? 32'hFFFF_FFFF
                      : 32'h2008_0001 + (imem_addr >> 2) * 32'h0001_0001;

  // Reference model state
  logic [31:0] m_pc, m_ptgt, m_instr, m_pcp4, m_count;
  logic        m_pend, m_valid, m_halted;
  logic [31:0] m_word, m_tgt;
  logic        m_moving, m_jump;

  always_comb begin
    m_word   = (halt_en && m_pc == halt_addr) ? 32'hFFFF_FFFF
               : 32'h2008_0001 + (m_pc >> 2) * 32'h0001_0001;
    m_tgt    = {(Jump_kind ? reg_target[31:2] : imm_target[31:2]), 2'b00};
    m_moving = !(m_halted || PC_NOPE);
    m_jump   = m_moving && (redirect_valid || m_pend);
  end

  // Model: what the stage must look like after each edge
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_pc <= 0; m_ptgt <= 0; m_pend <= 0; m_instr <= 0; m_pcp4 <= 0;
      m_valid <= 0; m_count <= 0; m_halted <= 0;
    end else begin
      if (m_moving)
        m_pc <= redirect_valid ? m_tgt : (m_pend ? m_ptgt : m_pc + 4);
      if (!m_halted && redirect_valid && PC_NOPE) begin
        m_pend <= 1; m_ptgt <= m_tgt;
      end else if (m_jump) begin
        m_pend <= 0;
      end
      if (IF_ID_Reg_Rst || m_halted || m_jump) begin
        m_instr <= 0; m_pcp4 <= 0; m_valid <= 0;
      end else if (!PC_NOPE) begin
        m_instr <= m_word; m_pcp4 <= m_pc + 4; m_valid <= 1;
        m_count <= m_count + 1;
        if (m_word == 32'hFFFF_FFFF) m_halted <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc_plus4", if_id_pc_plus4, m_pcp4);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("fetch_count", fetch_count, m_count);
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST_N = 0; PC_NOPE = 0; IF_ID_Reg_Rst = 0; Jump_kind = 0; redirect_valid = 0;
    imm_target = 0; reg_target = 0;
    cyc(2);
    chk("rst pc", pc, 32'h0);
    chk("rst valid", {31'b0, if_id_valid}, 32'h0);
    RST_N = 1;

    // Sequential fetch
    cyc(1);
    chk("seq1 pc", pc, 32'h4);
    chk("seq1 instr", if_id_instr, 32'h2008_0001);
    chk("seq1 pcp4", if_id_pc_plus4, 32'h4);
    chk("seq1 count", fetch_count, 32'd1);
    cyc(1);
    chk("seq2 instr", if_id_instr, 32'h2009_0002);
    chk("seq2 pcp4", if_id_pc_plus4, 32'h8);
    cyc(2);
    chk("seq4 pc", pc, 32'h10);
    chk("seq4 count", fetch_count, 32'd4);

    // Asynchronous reset mid-cycle
    #2 RST_N = 0;
    #1;
    chk("async pc", pc, 32'h0);
    chk("async instr", if_id_instr, 32'h0);
    chk("async valid", {31'b0, if_id_valid}, 32'h0);
    chk("async count", fetch_count, 32'h0);
    cyc(1);
    RST_N = 1;
    cyc(2);
    chk("rerun pc", pc, 32'h8);

    // Stall two cycles, then stall plus flush
    PC_NOPE = 1;
    cyc(2);
    chk("stall pc", pc, 32'h8);
    chk("stall instr", if_id_instr, 32'h2009_0002);
    chk("stall count", fetch_count, 32'd2);
    IF_ID_Reg_Rst = 1;
    cyc(1);
    chk("flush pc", pc, 32'h8);
    chk("flush valid", {31'b0, if_id_valid}, 32'h0);
    chk("flush count", fetch_count, 32'd2);
    PC_NOPE = 0; IF_ID_Reg_Rst = 0;
    cyc(1);
    chk("resume pc", pc, 32'hC);
    chk("resume instr", if_id_instr, 32'h200A_0003);

    // Immediate redirect without stall
    redirect_valid = 1; Jump_kind = 0; imm_target = 32'h40;
    cyc(1);
    redirect_valid = 0;
    chk("jmp pc", pc, 32'h40);
    chk("jmp valid", {31'b0, if_id_valid}, 32'h0);
    cyc(1);
    chk("jmp next pc", pc, 32'h44);
    chk("jmp instr", if_id_instr, 32'h2018_0011);

    // JR during a 4-cycle stall becomes pending
    PC_NOPE = 1; redirect_valid = 1; Jump_kind = 1; reg_target = 32'h83;
    cyc(1);
    redirect_valid = 0;
    cyc(3);
    chk("jr held pc", pc, 32'h44);
    chk("jr held instr", if_id_instr, 32'h2018_0011);
    PC_NOPE = 0;
    cyc(1);
    chk("jr pc", pc, 32'h80);
    chk("jr valid", {31'b0, if_id_valid}, 32'h0);
    cyc(1);

    // Pending target overwritten by a newer redirect
    PC_NOPE = 1; redirect_valid = 1; Jump_kind = 0; imm_target = 32'h100;
    cyc(1);
    Jump_kind = 1; reg_target = 32'h205;
    cyc(1);
    redirect_valid = 0; PC_NOPE = 0;
    cyc(1);
    chk("overwrite pc", pc, 32'h204);

    // PC wraps at the top of the address space
    redirect_valid = 1; Jump_kind = 0; imm_target = 32'hFFFF_FFFE;
    cyc(1);
    redirect_valid = 0;
    chk("wrap tgt pc", pc, 32'hFFFF_FFFC);
    cyc(1);
    chk("wrap pc", pc, 32'h0);
    chk("wrap pcp4", if_id_pc_plus4, 32'h0);

    // Halt word at 0x0C
    halt_en = 1; halt_addr = 32'hC;
    redirect_valid = 1; imm_target = 32'h8;
    cyc(1);
    redirect_valid = 0;
    cyc(2);
    chk("halt flag", {31'b0, halted}, 32'h1);
    chk("halt instr", if_id_instr, 32'hFFFF_FFFF);
    chk("halt valid", {31'b0, if_id_valid}, 32'h1);
    chk("halt pc", pc, 32'h10);
    cyc(1);
    chk("halted bubble", {31'b0, if_id_valid}, 32'h0);
    redirect_valid = 1; imm_target = 32'h300;
    cyc(1);
    redirect_valid = 0;
    cyc(2);
    chk("halted redirect pc", pc, 32'h10);
    chk("halted sticky", {31'b0, halted}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
